// File: rtl/dip_replacement_unit.sv
// Per-set tree-PLRU replacement engine with LRU/BIP set dueling for the data cache.
// victim_way is combinational (zero latency); updates commit at the next edge; no backpressure, every fill pulse is taken.
module dip_replacement_unit #(
  parameter  int NUM_WAYS     = 4,
  parameter  int INDEX_WIDTH  = 5,
  parameter  int PSEL_WIDTH   = 10,
  parameter  int BIP_EPS_LOG2 = 5,
  parameter  int LEADER_LOG2  = 3,
  localparam int WAY_W        = $clog2(NUM_WAYS),
  localparam int DEPTH        = 2 ** INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lookup_valid,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  input  logic                   lookup_hit,
  input  logic [WAY_W-1:0]       lookup_way,
  input  logic [NUM_WAYS-1:0]    set_valid_mask,
  output logic [WAY_W-1:0]       victim_way,
  input  logic                   fill_valid,
  input  logic [INDEX_WIDTH-1:0] fill_index,
  input  logic [WAY_W-1:0]       fill_way,
  output logic                   policy_bip,
  output logic [PSEL_WIDTH-1:0]  psel
);

  typedef logic [NUM_WAYS-2:0] tree_t;

  localparam logic [PSEL_WIDTH-1:0] PSEL_INIT = {1'b0, {(PSEL_WIDTH-1){1'b1}}};

  tree_t                   plru_q [DEPTH];
  logic [BIP_EPS_LOG2-1:0] bip_ctr_q;
  logic [PSEL_WIDTH-1:0]   psel_q;

  // Heap node n lives at bit n-1; each node on w's path is pointed away from w.
  function automatic tree_t promote(input tree_t t, input logic [WAY_W-1:0] w);
    tree_t r;
    int    node;
    r = t;
    for (int l = 0; l < WAY_W; l++) begin
      node        = (1 << l) | (int'(w) >> (WAY_W - l));
      r[node - 1] = ~w[WAY_W - 1 - l];
    end
    return r;
  endfunction

  tree_t            cur_tree;
  int               walk_node;
  logic [WAY_W-1:0] tree_victim;
  logic [WAY_W-1:0] inv_way;
  logic             inv_found;

  always_comb begin
    cur_tree    = plru_q[lookup_index];
    walk_node   = 1;
    tree_victim = '0;
    inv_way     = '0;
    inv_found   = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      walk_node = 2 * walk_node + int'(cur_tree[walk_node - 1]);
    end
    tree_victim = WAY_W'(walk_node - NUM_WAYS);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!set_valid_mask[w]) begin
        inv_way   = WAY_W'(w);
        inv_found = 1'b1;
      end
    end
    victim_way = inv_found ? inv_way : tree_victim;
  end

  logic [LEADER_LOG2-1:0] fill_low;
  logic                   lru_leader;
  logic                   bip_leader;
  logic                   fill_uses_bip;
  logic                   fill_promote;
  logic                   hit_update;

  assign fill_low      = fill_index[LEADER_LOG2-1:0];
  assign lru_leader    = (fill_low == '0);
  assign bip_leader    = &fill_low;
  assign fill_uses_bip = bip_leader | (!lru_leader & policy_bip);
  assign fill_promote  = fill_valid & (!fill_uses_bip | (bip_ctr_q == '0));
  // A fill to the same set takes precedence over a concurrent hit.
  assign hit_update    = lookup_valid & lookup_hit
                         & !(fill_valid && (fill_index == lookup_index));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) plru_q[i] <= '0;
      bip_ctr_q <= '0;
      psel_q    <= PSEL_INIT;
    end else begin
      if (hit_update)   plru_q[lookup_index] <= promote(plru_q[lookup_index], lookup_way);
      if (fill_promote) plru_q[fill_index]   <= promote(plru_q[fill_index], fill_way);
      if (fill_valid) begin
        bip_ctr_q <= bip_ctr_q + BIP_EPS_LOG2'(1);
        if (lru_leader && (psel_q != '1))      psel_q <= psel_q + PSEL_WIDTH'(1);
        else if (bip_leader && (psel_q != '0)) psel_q <= psel_q - PSEL_WIDTH'(1);
      end
    end
  end

  assign psel       = psel_q;
  assign policy_bip = psel_q[PSEL_WIDTH-1];

endmodule

// File: tb/tb_dip_replacement_unit.sv
// Scoreboard bench for dip_replacement_unit at default parameters (4 ways, 32 sets).
module tb_dip_replacement_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lookup_valid;
  logic [4:0] lookup_index;
  logic       lookup_hit;
  logic [1:0] lookup_way;
  logic [3:0] set_valid_mask;
  logic [1:0] victim_way;
  logic       fill_valid;
  logic [4:0] fill_index;
  logic [1:0] fill_way;
  logic       policy_bip;
  logic [9:0] psel;

  int    errors = 0;
  int    checks = 0;
  int    exp_q[$];
  string name_q[$];

  dip_replacement_unit dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index),
    .lookup_hit(lookup_hit), .lookup_way(lookup_way),
    .set_valid_mask(set_valid_mask), .victim_way(victim_way),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
    .policy_bip(policy_bip), .psel(psel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_way = '0;
    fill_valid = 1'b0; fill_index = '0; fill_way = '0;
    set_valid_mask = 4'hF;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_n(input int idx, input int way, input int n);
    for (int i = 0; i < n; i++) begin
      fill_valid = 1'b1; fill_index = 5'(idx); fill_way = 2'(way);
      tick();
    end
    fill_valid = 1'b0;
  endtask

  task automatic test_reset();
    int e; string nm;
    do_reset();
    lookup_index = 5'd3; set_valid_mask = 4'hF;
    exp_q.push_back(0);   name_q.push_back("reset_victim");
    exp_q.push_back(511); name_q.push_back("reset_psel");
    exp_q.push_back(0);   name_q.push_back("reset_policy");
    #1;
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(psel) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, psel, e); end
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(policy_bip) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, policy_bip, e); end
  endtask

  task automatic test_hit_update();
    int e; string nm;
    do_reset();
    lookup_valid = 1'b1; lookup_index = 5'd5; lookup_hit = 1'b1; lookup_way = 2'd0;
    exp_q.push_back(0); name_q.push_back("hit_same_cycle_victim");
    exp_q.push_back(2); name_q.push_back("hit_w0_victim");
    exp_q.push_back(1); name_q.push_back("hit_w2_victim");
    #1;
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    tick();
    lookup_valid = 1'b0; lookup_hit = 1'b0;
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_way = 2'd2;
    tick();
    lookup_valid = 1'b0; lookup_hit = 1'b0;
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
  endtask

  task automatic test_invalid_mask();
    int e; string nm;
    logic [3:0] masks [3];
    int         exps  [3];
    masks[0] = 4'b1011; exps[0] = 2;
    masks[1] = 4'b0000; exps[1] = 0;
    masks[2] = 4'b0111; exps[2] = 3;
    lookup_index = 5'd5;
    for (int i = 0; i < 3; i++) begin
      set_valid_mask = masks[i];
      exp_q.push_back(exps[i]); name_q.push_back($sformatf("mask_%b", masks[i]));
      #1;
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    end
    set_valid_mask = 4'hF;
  endtask

  task automatic test_psel_sat();
    int e; string nm;
    do_reset();
    fill_n(0, 0, 1);
    exp_q.push_back(512); name_q.push_back("one_lru_fill_psel");
    exp_q.push_back(1);   name_q.push_back("one_lru_fill_policy");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(psel) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, psel, e); end
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(policy_bip) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, policy_bip, e); end
    do_reset();
    fill_n(7, 1, 600);
    exp_q.push_back(0); name_q.push_back("bip_leader_sat_psel");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(psel) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, psel, e); end
    fill_n(0, 1, 511);
    exp_q.push_back(511); name_q.push_back("lru_leader_511_psel");
    exp_q.push_back(0);   name_q.push_back("lru_leader_511_policy");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(psel) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, psel, e); end
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(policy_bip) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, policy_bip, e); end
    fill_n(0, 1, 1);
    exp_q.push_back(512); name_q.push_back("lru_leader_512_psel");
    exp_q.push_back(1);   name_q.push_back("lru_leader_512_policy");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(psel) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, psel, e); end
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(policy_bip) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, policy_bip, e); end
    fill_n(0, 1, 600);
    exp_q.push_back(1023); name_q.push_back("lru_leader_sat_psel");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(psel) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, psel, e); end
  endtask

  task automatic test_bip_insert();
    int e; string nm;
    do_reset();
    fill_n(0, 0, 1);              // psel -> 512 (BIP followers), bip_ctr -> 1
    lookup_index = 5'd9; set_valid_mask = 4'hF;
    fill_n(9, 0, 1);              // bip_ctr was 1: no promotion, now 2
    exp_q.push_back(0); name_q.push_back("bip_fill_no_promote");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    fill_n(10, 3, 30);            // bip_ctr 2 -> 0
    exp_q.push_back(0); name_q.push_back("bip_other_fills_victim");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    fill_n(9, 0, 1);
    exp_q.push_back(2); name_q.push_back("bip_fill_ctr0_promote");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
  endtask

  task automatic test_back_to_back();
    int e; string nm;
    do_reset();
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_way = 2'd3; lookup_index = 5'd4;
    fill_valid = 1'b1; fill_index = 5'd4; fill_way = 2'd1;
    tick();
    idle();
    lookup_index = 5'd4;
    exp_q.push_back(2); name_q.push_back("same_set_hit_dropped");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    do_reset();
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_way = 2'd3; lookup_index = 5'd6;
    fill_valid = 1'b1; fill_index = 5'd4; fill_way = 2'd1;
    exp_q.push_back(2); name_q.push_back("diff_set_fill_victim");
    exp_q.push_back(0); name_q.push_back("diff_set_hit_victim");
    tick();
    idle();
    lookup_index = 5'd4; #1;
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    lookup_index = 5'd6; #1;
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    // Set 6 had hit way 3 -> victim 0; a second hit on way 0 should move it to 2.
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_way = 2'd0;
    tick();
    idle();
    lookup_index = 5'd6;
    exp_q.push_back(2); name_q.push_back("second_hit_victim");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
  endtask

  task automatic test_reset_mid();
    int e; string nm;
    do_reset();
    fill_n(0, 0, 3);
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_way = 2'd0; lookup_index = 5'd5;
    fill_valid = 1'b1; fill_index = 5'd0; fill_way = 2'd1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    lookup_index = 5'd5;
    exp_q.push_back(0);   name_q.push_back("mid_reset_victim");
    exp_q.push_back(511); name_q.push_back("mid_reset_psel");
    #1;
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(victim_way) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, victim_way, e); end
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (int'(psel) !== e) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, psel, e); end
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_index = '0;
    idle();
    test_reset();
    test_hit_update();
    test_invalid_mask();
    test_psel_sat();
    test_bip_insert();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
